// File: rtl/scoot_pkg.sv
// Shared definitions for the scootBot agent and its grid world: FSM state
// encoding, neighbour/direction bit positions and toroidal wrap helpers.
package scoot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SENSE = 3'd1,
    WAIT  = 3'd2,
    MOVE  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bit positions of the four neighbour/move directions in a 4-bit vector
  localparam int UP    = 0;
  localparam int RIGHT = 1;
  localparam int DOWN  = 2;
  localparam int LEFT  = 3;

  // value+1 modulo modulus (value assumed already in range)
  function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned modulus);
    return (value + 32'd1 >= modulus) ? 32'd0 : value + 32'd1;
  endfunction

  // value-1 modulo modulus (value assumed already in range)
  function automatic int unsigned wrap_dec(input int unsigned value, input int unsigned modulus);
    return (value == 32'd0) ? modulus - 32'd1 : value - 32'd1;
  endfunction

endpackage

// File: rtl/scoot_world_if.sv
// Bundle between the grid world and its host/bot side: run control, map
// loading, bot move requests, neighbour sensors and run status.
interface scoot_world_if #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 10,
  parameter int SCORE_W = 8
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic               start;
  logic               load_we;
  logic [XW-1:0]      load_row;
  logic [HEIGHT-1:0]  load_data;
  logic               mUp;
  logic               mRight;
  logic               mDown;
  logic               mLeft;
  logic               lUp;
  logic               lRight;
  logic               lDown;
  logic               lLeft;
  logic [XW-1:0]      pos_x;
  logic [YW-1:0]      pos_y;
  logic               pickup;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;

  // Host / bot side
  modport master (
    output start, load_we, load_row, load_data,
    output mUp, mRight, mDown, mLeft,
    input  lUp, lRight, lDown, lLeft,
    input  pos_x, pos_y, pickup, score, busy, done
  );

  // World side
  modport slave (
    input  start, load_we, load_row, load_data,
    input  mUp, mRight, mDown, mLeft,
    output lUp, lRight, lDown, lLeft,
    output pos_x, pos_y, pickup, score, busy, done
  );

endinterface

// File: rtl/scoot_food_map.sv
// Toroidal WIDTH x HEIGHT food map. Row index is x, bit index within a row
// is y. One row write port, one single-cell clear port and five combinational
// read taps (centre plus four wrapped neighbours).
module scoot_food_map
  import scoot_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [XW-1:0]     wr_row,
  input  logic [HEIGHT-1:0] wr_data,
  input  logic              clr_en,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  output logic              centre,
  output logic [3:0]        nbr
);

  logic [HEIGHT-1:0] cells [WIDTH];
  logic [XW-1:0]     x_inc;
  logic [XW-1:0]     x_dec;
  logic [YW-1:0]     y_inc;
  logic [YW-1:0]     y_dec;

  assign x_inc = XW'(wrap_inc(32'(x), WIDTH));
  assign x_dec = XW'(wrap_dec(32'(x), WIDTH));
  assign y_inc = YW'(wrap_inc(32'(y), HEIGHT));
  assign y_dec = YW'(wrap_dec(32'(y), HEIGHT));

  // Map storage: cleared on reset, whole-row loads, single-cell eat
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cells[i] <= '0;
    end else begin
      if (wr_en && (32'(wr_row) < WIDTH)) cells[wr_row] <= wr_data;
      if (clr_en) cells[x][y] <= 1'b0;
    end
  end

  // Centre and wrapped neighbour read taps
  always_comb begin
    nbr        = '0;
    centre     = cells[x][y];
    nbr[UP]    = cells[x][y_inc];
    nbr[RIGHT] = cells[x_inc][y];
    nbr[DOWN]  = cells[x][y_dec];
    nbr[LEFT]  = cells[x_dec][y];
  end

endmodule

// File: rtl/scoot_world.sv
// Grid-world environment for the scootBot agent. Holds the food map, tracks
// the bot position, presents neighbour-food sensors, samples one move per
// step, eats food and keeps a saturating score used as the fitness figure.
// Optional build macro SCOOT_WORLD_TRACE_EN: prints "x,y" every SENSE step
// and "PickedUp" on each pickup for the host log parser (simulation only).
module scoot_world
  import scoot_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int HEIGHT        = 10,
  parameter int NUM_STEPS     = 100,
  parameter int SETTLE_CYCLES = 8,
  parameter int SCORE_W       = 8
) (
  input  logic         clk,
  input  logic         reset,
  scoot_world_if.slave bus
);

  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [XW-1:0]     X_HOME    = XW'(WIDTH / 2);
  localparam logic [YW-1:0]     Y_HOME    = YW'(HEIGHT / 2);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [XW-1:0]       x_nxt;
  logic [YW-1:0]       y_nxt;
  logic [SCORE_W-1:0]  score;
  logic [STEP_W-1:0]   step;
  logic [CNT_W-1:0]    wait_cnt;
  logic [3:0]          sensors;
  logic                pickup;
  logic                centre;
  logic [3:0]          nbr;
  logic                idle_like;
  logic                load_en;
  logic                eat;
  logic                go_right;
  logic                go_left;
  logic                go_up;
  logic                go_down;

  // Score increments but sticks at all-ones instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Loads and starts are only honoured while no run is in progress
  assign idle_like = (state == IDLE) || (state == DONE);
  assign load_en   = idle_like && bus.load_we;
  assign eat       = (state == SENSE) && centre;

  // Opposing requests cancel, so all four high means no move
  assign go_right = bus.mRight & ~bus.mLeft;
  assign go_left  = bus.mLeft  & ~bus.mRight;
  assign go_up    = bus.mUp    & ~bus.mDown;
  assign go_down  = bus.mDown  & ~bus.mUp;

  assign x_nxt = go_right ? XW'(wrap_inc(32'(x), WIDTH)) :
                 go_left  ? XW'(wrap_dec(32'(x), WIDTH)) : x;
  assign y_nxt = go_up    ? YW'(wrap_inc(32'(y), HEIGHT)) :
                 go_down  ? YW'(wrap_dec(32'(y), HEIGHT)) : y;

  scoot_food_map #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_map (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_en),
    .wr_row  (bus.load_row),
    .wr_data (bus.load_data),
    .clr_en  (eat),
    .x       (x),
    .y       (y),
    .centre  (centre),
    .nbr     (nbr)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: one SENSE, SETTLE_CYCLES of WAIT, one MOVE per step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = SENSE;
      SENSE:      state_nxt = WAIT;
      WAIT:       if (wait_cnt == LAST_WAIT) state_nxt = MOVE;
      MOVE:       state_nxt = (step == LAST_STEP) ? DONE : SENSE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM outputs: run status decoded from state
  always_comb begin
    bus.busy = (state == SENSE) || (state == WAIT) || (state == MOVE);
    bus.done = (state == DONE);
  end

  // Run datapath: position, score, step/settle counters, sensors, pickup
  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= X_HOME;
      y        <= Y_HOME;
      score    <= '0;
      step     <= '0;
      wait_cnt <= '0;
      sensors  <= '0;
      pickup   <= 1'b0;
    end else begin
      pickup <= eat;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            x     <= X_HOME;
            y     <= Y_HOME;
            score <= '0;
            step  <= '0;
          end
        end
        SENSE: begin
          if (centre) score <= sat_inc(score);
          sensors  <= nbr;
          wait_cnt <= '0;
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        MOVE: begin
          x    <= x_nxt;
          y    <= y_nxt;
          step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.lUp    = sensors[UP];
  assign bus.lRight = sensors[RIGHT];
  assign bus.lDown  = sensors[DOWN];
  assign bus.lLeft  = sensors[LEFT];
  assign bus.pos_x  = x;
  assign bus.pos_y  = y;
  assign bus.pickup = pickup;
  assign bus.score  = score;

`ifdef SCOOT_WORLD_TRACE_EN
  // Per-step position and pickup trace in the format the host parser expects
  always @(posedge clk) begin
    if (!reset && state == SENSE) begin
      $display("%d,%d", x, y);
      if (centre) $display("PickedUp");
    end
  end
`endif

endmodule

// File: tb/tb_scoot_world.sv
// Directed bench for scoot_world: a default instance and a SCORE_W=2
// instance share one stimulus stream; the second shows score saturation.
module tb_scoot_world;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       load_we = 1'b0;
  logic [3:0] load_row = '0;
  logic [9:0] load_data = '0;
  logic       m_up = 1'b0;
  logic       m_right = 1'b0;
  logic       m_down = 1'b0;
  logic       m_left = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_wait;

  always #5 clk = ~clk;

  scoot_world_if #(.WIDTH(10), .HEIGHT(10), .SCORE_W(8)) bus ();
  scoot_world_if #(.WIDTH(10), .HEIGHT(10), .SCORE_W(2)) sbus ();

  assign bus.start      = start;
  assign bus.load_we    = load_we;
  assign bus.load_row   = load_row;
  assign bus.load_data  = load_data;
  assign bus.mUp        = m_up;
  assign bus.mRight     = m_right;
  assign bus.mDown      = m_down;
  assign bus.mLeft      = m_left;
  assign sbus.start     = start;
  assign sbus.load_we   = load_we;
  assign sbus.load_row  = load_row;
  assign sbus.load_data = load_data;
  assign sbus.mUp       = m_up;
  assign sbus.mRight    = m_right;
  assign sbus.mDown     = m_down;
  assign sbus.mLeft     = m_left;

  scoot_world #(
    .WIDTH(10), .HEIGHT(10), .NUM_STEPS(100), .SETTLE_CYCLES(8), .SCORE_W(8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  scoot_world #(
    .WIDTH(10), .HEIGHT(10), .NUM_STEPS(100), .SETTLE_CYCLES(8), .SCORE_W(2)
  ) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(bus.pos_x), ex);
    check({tag, ".y"}, 32'(bus.pos_y), ey);
  endtask

  function automatic logic [31:0] sens();
    return 32'({bus.lUp, bus.lRight, bus.lDown, bus.lLeft});
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load(input logic [3:0] row, input logic [9:0] data);
    load_we   = 1'b1;
    load_row  = row;
    load_data = data;
    tick(1);
    load_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < max_cycles) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.score", 32'(bus.score), 0);
    check("rst.pickup", 32'(bus.pickup), 0);
    check("rst.sens", sens(), 0);
    check_pos("rst.pos", 5, 5);
    reset = 1'b0;
    tick(1);

    // Empty map, bot always moves right: x wraps 9 -> 0, y fixed
    m_right = 1'b1;
    do_start();
    check("run.busy", 32'(bus.busy), 1);
    check_pos("run.s0", 5, 5);
    tick(10);
    check_pos("run.s1", 6, 5);
    tick(30);
    check_pos("run.s4", 9, 5);
    tick(10);
    check_pos("run.s5", 0, 5);
    wait_done(2000, n_wait);
    check("run.done_cycles", 32'(n_wait), 950);
    check("run.done", 32'(bus.done), 1);
    check("run.busy_end", 32'(bus.busy), 0);
    check("run.score", 32'(bus.score), 0);
    check_pos("run.end", 5, 5);
    tick(5);
    check("run.done_held", 32'(bus.done), 1);
    check_pos("run.frozen", 5, 5);

    // Food at the start cell: pickup pulse, score 1, cell eaten
    m_right = 1'b0;
    pulse_reset();
    load(4'd5, 10'b0000100000);
    do_start();
    check("eat.pickup_sense", 32'(bus.pickup), 0);
    tick(1);
    check("eat.pickup", 32'(bus.pickup), 1);
    check("eat.score", 32'(bus.score), 1);
    tick(1);
    check("eat.pickup_end", 32'(bus.pickup), 0);
    tick(9);
    check("eat.again_pickup", 32'(bus.pickup), 0);
    check("eat.again_score", 32'(bus.score), 1);

    // Four neighbours fed; last row written in the same cycle as start
    pulse_reset();
    load(4'd4, 10'b0000100000);
    load(4'd6, 10'b0000100000);
    load_we   = 1'b1;
    load_row  = 4'd5;
    load_data = 10'b0001010000;
    start     = 1'b1;
    tick(1);
    load_we   = 1'b0;
    start     = 1'b0;
    tick(1);
    check("nbr.sens", sens(), 32'hF);
    check("nbr.score", 32'(bus.score), 0);

    // Walk diagonally to (0,0): left/down neighbours wrap to x=9 / y=9
    pulse_reset();
    load(4'd9, 10'b0000000001);
    load(4'd0, 10'b1000000000);
    m_left = 1'b1;
    m_down = 1'b1;
    do_start();
    tick(51);
    check_pos("wrap.pos", 0, 0);
    check("wrap.sens", sens(), 32'h3);
    // Up and down cancel, left still applies: x wraps to 9
    m_up = 1'b1;
    tick(9);
    check_pos("cancel.ud", 9, 0);
    // All four high: no move
    m_right = 1'b1;
    tick(11);
    check_pos("cancel.all", 9, 0);
    check("cancel.sens", sens(), 0);

    // Busy load ignored; mid-run reset clears everything including the map
    m_up = 1'b0;
    m_down = 1'b0;
    m_left = 1'b0;
    m_right = 1'b1;
    pulse_reset();
    load(4'd5, 10'b0001100000);
    do_start();
    tick(1);
    check("mid.score1", 32'(bus.score), 1);
    check("mid.lup1", 32'(bus.lUp), 1);
    tick(48);
    load(4'd5, 10'b0000000000);
    tick(51);
    check_pos("mid.s10", 5, 5);
    check("mid.lup_kept", 32'(bus.lUp), 1);
    tick(269);
    check_pos("mid.s37", 2, 5);
    check("mid.busy37", 32'(bus.busy), 1);
    pulse_reset();
    check("mid.rst_busy", 32'(bus.busy), 0);
    check("mid.rst_score", 32'(bus.score), 0);
    check("mid.rst_done", 32'(bus.done), 0);
    check_pos("mid.rst_pos", 5, 5);
    m_right = 1'b0;
    do_start();
    tick(1);
    check("mid.map_clear_lup", 32'(bus.lUp), 0);
    check("mid.map_clear_score", 32'(bus.score), 0);

    // Five food cells on the path: 8-bit score reaches 5, 2-bit sticks at 3
    pulse_reset();
    load(4'd6, 10'b0000100000);
    load(4'd7, 10'b0000100000);
    load(4'd8, 10'b0000100000);
    load(4'd9, 10'b0000100000);
    load(4'd0, 10'b0000100000);
    m_right = 1'b1;
    do_start();
    tick(51);
    check("sat.main_score", 32'(bus.score), 5);
    check("sat.sat_score", 32'(sbus.score), 3);
    wait_done(2000, n_wait);
    check("sat.done_cycles", 32'(n_wait), 949);
    check("sat.sat_done", 32'(sbus.done), 1);
    check("sat.sat_final", 32'(sbus.score), 3);
    check("sat.main_final", 32'(bus.score), 5);
    // Restart from DONE: score cleared, food stays eaten
    do_start();
    check("re.done", 32'(bus.done), 0);
    check("re.busy", 32'(bus.busy), 1);
    check("re.score", 32'(bus.score), 0);
    check("re.sat_score", 32'(sbus.score), 0);
    tick(51);
    check("re.score_s5", 32'(bus.score), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
